// File: rtl/cpu_pkg.sv
// Shared constants for the CPU memory subsystem: port identifiers, arbiter
// FSM states and default bus widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic: loader lock first, then single requester, then
// round robin against the last granted port.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic ext_lock,
  output logic grant_valid,
  output logic grant
);

  logic last_grant;

  always_comb begin
    grant_valid = cpu_req | ext_req;
    grant       = PORT_CPU;
    if (ext_req && (ext_lock || !cpu_req)) begin
      grant = PORT_EXT;
    end else if (cpu_req && ext_req) begin
      grant = (last_grant == PORT_CPU) ? PORT_EXT : PORT_CPU;
    end
  end

  // Reset to EXT so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_EXT;
    end else if (en && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU and loader accesses onto the single-port RAM with a
// fixed-latency cycle, one-cycle ack and a stall back to the controller.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_lock,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             port;
  logic             we_q;
  logic             arb_en;
  logic             grant_valid;
  logic             grant;

  assign arb_en    = (state == ST_IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .cpu_req    (cpu_req),
    .ext_req    (ext_req),
    .ext_lock   (ext_lock),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      port      <= PORT_CPU;
      we_q      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            port <= grant;
            if (grant == PORT_EXT) begin
              ram_addr  <= ext_addr;
              ram_we    <= ext_we;
              ram_wdata <= ext_wdata;
              we_q      <= ext_we;
            end else begin
              ram_addr  <= cpu_addr;
              ram_we    <= cpu_we;
              ram_wdata <= cpu_wdata;
              we_q      <= cpu_we;
            end
            ram_en  <= 1'b1;
            busy    <= 1'b1;
            lat_cnt <= LAT_W'(RAM_LAT - 1);
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Write strobe lasts only the first ACCESS cycle.
          ram_we <= 1'b0;
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            if (!we_q) begin
              if (port == PORT_EXT) ext_rdata <= ram_rdata;
              else                  cpu_rdata <= ram_rdata;
            end
            if (port == PORT_EXT) ext_ack <= 1'b1;
            else                  cpu_ack <= 1'b1;
            ram_en <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          cpu_ack <= 1'b0;
          ext_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
